// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage.
// Owns the architectural HI/LO registers. It executes mult, multu, div, divu,
// mthi and mtlo, and supplies mfhi/mflo read data to the E->M pipeline.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
// Ports:
//   clk       clock
//   reset     asynchronous, active-low reset
//   md_op     E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//             6 MTLO, 7 reserved (NONE)
//   md_a      rs operand (forwarded)
//   md_b      rt operand (forwarded)
//   rd_sel    read select: 0 LO, 1 HI
//   req       CP0 exception/interrupt request; blocks issue this cycle
//   d_md_use  D-stage instruction uses the MDU or HI/LO
//   md_rdata  committed HI or LO value
//   busy      computation in flight (FSM is in RUN)
//   stall     D-stage stall request
//
// Handshake: an op is accepted ("issue") on a clock edge where md_op is a
// valid op, req=0, busy=0 and reset is high. busy=1 means the unit is not ready;
// the hazard unit holds D-stage MDU instructions via stall while busy.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        rd_sel,
  input  logic        req,
  input  logic        d_md_use,
  output logic [31:0] md_rdata,
  output logic        busy,
  output logic        stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // The FSM state is fully encoded by cnt; this enum names it.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;

  logic [31:0]   hi, lo, res_hi, res_lo;
  logic [CW-1:0] cnt;
  logic          res_skip;   // pending op was a divide by zero
  md_state_e     state;

  logic          op_valid, op_calc, issue;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   div_s_b, div_u_b, quot_s, rem_s, quot_u, rem_u;
  logic          div_ovf;

  assign state    = (cnt != '0) ? RUN : IDLE;
  assign busy     = (state == RUN);
  assign op_valid = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
  assign op_calc  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign issue    = op_valid && !req && !busy && reset;
  assign stall    = d_md_use && (busy || (issue && op_calc));
  assign md_rdata = rd_sel ? hi : lo;

  // Products in 64 bits; the sign-extended operands give the signed product.
  assign prod_s = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
  assign prod_u = {32'd0, md_a} * {32'd0, md_b};

  // Divisor is forced to 1 for /0 (result discarded anyway) and for
  // 0x80000000 / -1, where dividing by 1 yields exactly LO=0x80000000, HI=0.
  assign div_ovf = (md_a == 32'h8000_0000) && (md_b == 32'hFFFF_FFFF);
  assign div_s_b = ((md_b == 32'd0) || div_ovf) ? 32'd1 : md_b;
  assign div_u_b = (md_b == 32'd0) ? 32'd1 : md_b;
  assign quot_s  = $signed(md_a) / $signed(div_s_b);
  assign rem_s   = $signed(md_a) % $signed(div_s_b);
  assign quot_u  = md_a / div_u_b;
  assign rem_u   = md_a % div_u_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_skip <= 1'b0;
      cnt      <= '0;
    end else if (busy) begin
      // In-flight ops ignore req and always complete.
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && !res_skip) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (issue) begin
      case (md_op)
        OP_MULT: begin
          {res_hi, res_lo} <= prod_s;
          res_skip         <= 1'b0;
          cnt              <= CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {res_hi, res_lo} <= prod_u;
          res_skip         <= 1'b0;
          cnt              <= CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          res_lo   <= quot_s;
          res_hi   <= rem_s;
          res_skip <= (md_b == 32'd0);
          cnt      <= CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          res_lo   <= quot_u;
          res_hi   <= rem_u;
          res_skip <= (md_b == 32'd0);
          cnt      <= CW'(DIV_CYCLES);
        end
        OP_MTHI: hi <= md_a;
        OP_MTLO: lo <= md_a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        rd_sel, req, d_md_use;
  logic [31:0] md_rdata;
  logic        busy, stall;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .rd_sel(rd_sel), .req(req), .d_md_use(d_md_use),
    .md_rdata(md_rdata), .busy(busy), .stall(stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: returns committed {hi,lo} after the op.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    model = {h, l};
    case (op)
      3'd1: begin p = sa * sb; model = p; end
      3'd2: begin p = ua * ub; model = p; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      3'd4: if (b != 0) begin q = ua / ub; r = ua % ub; model = {r[31:0], q[31:0]}; end
      3'd5: model = {a, l};
      3'd6: model = {h, b == b ? a : a};
      default: ;
    endcase
  endfunction

  task automatic read_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      rd_sel = 1'b1; #1;
      check({tag, "_hi"}, 64'(md_rdata), 64'(e[63:32]));
      rd_sel = 1'b0; #1;
      check({tag, "_lo"}, 64'(md_rdata), 64'(e[31:0]));
    end
  endtask

  // Driver: called at a negedge with the unit idle; returns at the negedge of
  // the first idle cycle after completion so the next op can issue at once.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmu, input string tag);
    logic        calc;
    logic [31:0] old_lo;
    logic [63:0] nxt;
    int          n, exp_n;
    calc   = (op >= 3'd1) && (op <= 3'd4);
    exp_n  = (op >= 3'd3) ? DIV_CYCLES : MULT_CYCLES;
    old_lo = lo_m;
    nxt    = model(op, a, b, hi_m, lo_m);
    exp_q.push_back(nxt);
    {hi_m, lo_m} = nxt;
    md_op = op; md_a = a; md_b = b; d_md_use = dmu; req = 1'b0; rd_sel = 1'b0;
    #1;
    check({tag, "_stall_issue"}, 64'(stall), 64'(dmu && calc));
    @(posedge clk); #1;
    md_op = 3'd0;
    if (calc) begin
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
        if (n == 1) begin
          check({tag, "_old_lo"}, 64'(md_rdata), 64'(old_lo));
          check({tag, "_stall_busy"}, 64'(stall), 64'(dmu));
        end
      end
      check({tag, "_busy_len"}, 64'(n), 64'(exp_n));
      check({tag, "_stall_end"}, 64'(stall), 64'd0);
    end else begin
      @(negedge clk);
      check({tag, "_no_busy"}, 64'(busy), 64'd0);
    end
    read_check(tag);
  endtask

  initial begin
    reset = 1'b0; md_op = 3'd1; md_a = 32'd3; md_b = 32'd4;
    rd_sel = 1'b0; req = 1'b0; d_md_use = 1'b1;
    hi_m = '0; lo_m = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_lo", 64'(md_rdata), 64'd0);
    rd_sel = 1'b1; #1;
    check("rst_hi", 64'(md_rdata), 64'd0);
    repeat (2) @(posedge clk);
    check("rst_hold_busy", 64'(busy), 64'd0);
    @(negedge clk);
    md_op = 3'd0; reset = 1'b1;
    @(negedge clk);

    run_op(3'd6, 32'h0000_AAAA, 32'd0, 1'b0, "mtlo_a");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, "mult_neg");
    check("mult_neg_lo_val", 64'(lo_m), 64'hFFFF_FFF1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_neg");
    run_op(3'd5, 32'h11, 32'd0, 1'b0, "mthi_11");
    run_op(3'd6, 32'h22, 32'd0, 1'b0, "mtlo_22");
    run_op(3'd4, 32'd7, 32'd0, 1'b1, "divu_zero");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(3'd3, 32'd100, 32'd0, 1'b0, "div_zero");

    // MULT with req: dropped, no state change
    md_op = 3'd1; md_a = 32'd9; md_b = 32'd9; req = 1'b1; d_md_use = 1'b1;
    #1;
    check("req_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    md_op = 3'd0; req = 1'b0;
    check("req_busy", 64'(busy), 64'd0);
    exp_q.push_back({hi_m, lo_m});
    @(negedge clk);
    read_check("req");

    run_op(3'd5, 32'h1234, 32'd0, 1'b0, "mthi_1234");

    for (int k = 0; k < 24; k++) begin
      run_op(3'($urandom_range(1, 6)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             1'($urandom_range(0, 1)), "rnd");
    end

    // reset in the middle of a divide
    run_op(3'd5, 32'h55, 32'd0, 1'b0, "mthi_55");
    run_op(3'd6, 32'h66, 32'd0, 1'b0, "mtlo_66");
    md_op = 3'd3; md_a = 32'd50; md_b = 32'd3; d_md_use = 1'b1;
    @(posedge clk); #1;
    md_op = 3'd0;
    repeat (4) @(negedge clk);
    check("mid_busy_before", 64'(busy), 64'd1);
    reset = 1'b0; #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    rd_sel = 1'b0; #1;
    check("mid_rst_lo", 64'(md_rdata), 64'd0);
    rd_sel = 1'b1; #1;
    check("mid_rst_hi", 64'(md_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    hi_m = '0; lo_m = '0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    exp_q.push_back(64'd0);
    read_check("post_rst");

    check("q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
